// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every request, response and downstream bus signal
// around the memory arbiter.
//   IFU   : ifu_psel_i, ifu_paddr_i -> ifu_pready_o, ifu_prdata_o
//   LSU   : lsu_psel_i, lsu_pwrite_i, lsu_paddr_i, lsu_pwdata_i, lsu_pstrb_i
//           -> lsu_pready_o, lsu_prdata_o, lsu_pslverr_o
//   MEM   : mem_psel_o, mem_penable_o, mem_pwrite_o, mem_paddr_o,
//           mem_pwdata_o, mem_pstrb_o <- mem_pready_i, mem_prdata_i,
//           mem_pslverr_i
// Modports: slave  = the arbiter's view (sees *_i as inputs),
//           master = the surrounding environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  ifu_psel_i;
  logic [ADDR_WIDTH-1:0] ifu_paddr_i;
  logic                  ifu_pready_o;
  logic [DATA_WIDTH-1:0] ifu_prdata_o;

  logic                  lsu_psel_i;
  logic                  lsu_pwrite_i;
  logic [ADDR_WIDTH-1:0] lsu_paddr_i;
  logic [DATA_WIDTH-1:0] lsu_pwdata_i;
  logic [STRB_WIDTH-1:0] lsu_pstrb_i;
  logic                  lsu_pready_o;
  logic [DATA_WIDTH-1:0] lsu_prdata_o;
  logic                  lsu_pslverr_o;

  logic                  mem_psel_o;
  logic                  mem_penable_o;
  logic                  mem_pwrite_o;
  logic [ADDR_WIDTH-1:0] mem_paddr_o;
  logic [DATA_WIDTH-1:0] mem_pwdata_o;
  logic [STRB_WIDTH-1:0] mem_pstrb_o;
  logic                  mem_pready_i;
  logic [DATA_WIDTH-1:0] mem_prdata_i;
  logic                  mem_pslverr_i;

  modport slave (
    input  ifu_psel_i, ifu_paddr_i,
    output ifu_pready_o, ifu_prdata_o,
    input  lsu_psel_i, lsu_pwrite_i, lsu_paddr_i, lsu_pwdata_i, lsu_pstrb_i,
    output lsu_pready_o, lsu_prdata_o, lsu_pslverr_o,
    output mem_psel_o, mem_penable_o, mem_pwrite_o, mem_paddr_o,
    output mem_pwdata_o, mem_pstrb_o,
    input  mem_pready_i, mem_prdata_i, mem_pslverr_i
  );

  modport master (
    output ifu_psel_i, ifu_paddr_i,
    input  ifu_pready_o, ifu_prdata_o,
    output lsu_psel_i, lsu_pwrite_i, lsu_paddr_i, lsu_pwdata_i, lsu_pstrb_i,
    input  lsu_pready_o, lsu_prdata_o, lsu_pslverr_o,
    input  mem_psel_o, mem_penable_o, mem_pwrite_o, mem_paddr_o,
    input  mem_pwdata_o, mem_pstrb_o,
    output mem_pready_i, mem_prdata_i, mem_pslverr_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (IFU fetch, LSU load/store) arbiter in front of
// a single APB-style memory port. Each grant runs IDLE -> SETUP -> ACCESS and
// always returns to IDLE, where the next arbitration happens.
// Ports:
//   clock  - clock, all state updates on the rising edge
//   reset  - synchronous, active-high; aborts any transaction in flight
//   bus    - mem_arbiter_if.slave carrying IFU, LSU and memory signals
// Build option:
//   ARB_ROUND_ROBIN_EN undefined : fixed priority, LSU wins a tie
//   ARB_ROUND_ROBIN_EN defined   : a tie goes to the requester not granted
//                                  last (tracked in last_grant_r)
// Observable internals: state_r, grant_r (0=IFU, 1=LSU), grant_cnt_r.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt;
  logic                  grant_r;
  logic [31:0]           grant_cnt_r;

  logic                  mem_pwrite_r;
  logic [ADDR_WIDTH-1:0] mem_paddr_r;
  logic [DATA_WIDTH-1:0] mem_pwdata_r;
  logic [STRB_WIDTH-1:0] mem_pstrb_r;

  logic                  any_req;
  logic                  win_lsu;
  logic                  start;
  logic                  psel;
  logic                  penable;
  logic                  ifu_pready;
  logic                  lsu_pready;

  assign any_req = bus.ifu_psel_i | bus.lsu_psel_i;
  assign start   = (state_r == IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_r;

  // On a tie the LSU wins only if the IFU was granted last; a lone
  // requester wins no matter what last_grant_r says.
  assign win_lsu = bus.lsu_psel_i & (~bus.ifu_psel_i | ~last_grant_r);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_r <= 1'b0;
    end else if (start) begin
      last_grant_r <= win_lsu;
    end
  end
`else
  assign win_lsu = bus.lsu_psel_i;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state and bus/handshake decode
  always_comb begin
    state_nxt  = state_r;
    psel       = 1'b0;
    penable    = 1'b0;
    ifu_pready = 1'b0;
    lsu_pready = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (bus.mem_pready_i) begin
          state_nxt = IDLE;
          // A reset in the completing cycle aborts: no pulse escapes.
          if (!reset) begin
            lsu_pready = grant_r;
            ifu_pready = ~grant_r;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture: the winner's fields are frozen here until the next IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_r      <= 1'b0;
      grant_cnt_r  <= 32'd0;
      mem_pwrite_r <= 1'b0;
      mem_paddr_r  <= '0;
      mem_pwdata_r <= '0;
      mem_pstrb_r  <= '0;
    end else if (start) begin
      grant_r      <= win_lsu;
      grant_cnt_r  <= grant_cnt_r + 32'd1;
      mem_pwrite_r <= win_lsu & bus.lsu_pwrite_i;
      mem_paddr_r  <= win_lsu ? bus.lsu_paddr_i  : bus.ifu_paddr_i;
      mem_pwdata_r <= win_lsu ? bus.lsu_pwdata_i : '0;
      mem_pstrb_r  <= win_lsu ? bus.lsu_pstrb_i  : '0;
    end
  end

  assign bus.mem_psel_o    = psel;
  assign bus.mem_penable_o = penable;
  assign bus.mem_pwrite_o  = mem_pwrite_r;
  assign bus.mem_paddr_o   = mem_paddr_r;
  assign bus.mem_pwdata_o  = mem_pwdata_r;
  assign bus.mem_pstrb_o   = mem_pstrb_r;

  // Response data is forced to zero except during the owner's pulse.
  assign bus.ifu_pready_o  = ifu_pready;
  assign bus.ifu_prdata_o  = ifu_pready ? bus.mem_prdata_i : '0;
  assign bus.lsu_pready_o  = lsu_pready;
  assign bus.lsu_prdata_o  = lsu_pready ? bus.mem_prdata_i : '0;
  assign bus.lsu_pslverr_o = lsu_pready & bus.mem_pslverr_i;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the
// falling edge of the same cycle.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.ifu_psel_i    = 1'b0;
    bus.ifu_paddr_i   = 32'h0;
    bus.lsu_psel_i    = 1'b0;
    bus.lsu_pwrite_i  = 1'b0;
    bus.lsu_paddr_i   = 32'h0;
    bus.lsu_pwdata_i  = 32'h0;
    bus.lsu_pstrb_i   = 4'h0;
    bus.mem_pready_i  = 1'b0;
    bus.mem_prdata_i  = 32'h0;
    bus.mem_pslverr_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_psel"},    64'(bus.mem_psel_o),    64'd0);
    chk({tag, "_penable"}, 64'(bus.mem_penable_o), 64'd0);
    chk({tag, "_pwrite"},  64'(bus.mem_pwrite_o),  64'd0);
    chk({tag, "_paddr"},   64'(bus.mem_paddr_o),   64'd0);
    chk({tag, "_pwdata"},  64'(bus.mem_pwdata_o),  64'd0);
    chk({tag, "_pstrb"},   64'(bus.mem_pstrb_o),   64'd0);
    chk({tag, "_ifu_rdy"}, 64'(bus.ifu_pready_o),  64'd0);
    chk({tag, "_ifu_rd"},  64'(bus.ifu_prdata_o),  64'd0);
    chk({tag, "_lsu_rdy"}, 64'(bus.lsu_pready_o),  64'd0);
    chk({tag, "_lsu_rd"},  64'(bus.lsu_prdata_o),  64'd0);
    chk({tag, "_lsu_err"}, 64'(bus.lsu_pslverr_o), 64'd0);
    chk({tag, "_state"},   64'(dut.state_r),       64'd0);
    chk({tag, "_grant"},   64'(dut.grant_r),       64'd0);
    chk({tag, "_cnt"},     64'(dut.grant_cnt_r),   64'd0);
  endtask

  initial begin
    int pen;
    int rdy;
    int rdy_at;
    int n;
    int ifu_pulses;
    logic [3:0] who;
    logic [3:0] who_exp;

    // ---------------- reset state ----------------
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    sample();
    chk_zero("rst");
    next_cycle();
    reset = 1'b0;

    // ---------------- IFU alone, zero-wait memory ----------------
    next_cycle();                       // cycle N, IDLE
    bus.ifu_psel_i   = 1'b1;
    bus.ifu_paddr_i  = 32'h8000_0000;
    bus.mem_prdata_i = 32'h0000_0413;
    bus.mem_pready_i = 1'b1;            // must be ignored until ACCESS
    sample();
    chk("ifu_n_rdy",  64'(bus.ifu_pready_o), 64'd0);
    chk("ifu_n_psel", 64'(bus.mem_psel_o),   64'd0);
    next_cycle();                       // N+1, SETUP
    sample();
    chk("ifu_s_psel",  64'(bus.mem_psel_o),    64'd1);
    chk("ifu_s_pen",   64'(bus.mem_penable_o), 64'd0);
    chk("ifu_s_paddr", 64'(bus.mem_paddr_o),   64'h8000_0000);
    chk("ifu_s_pwr",   64'(bus.mem_pwrite_o),  64'd0);
    chk("ifu_s_pstrb", 64'(bus.mem_pstrb_o),   64'd0);
    chk("ifu_s_rdy",   64'(bus.ifu_pready_o),  64'd0);
    next_cycle();                       // N+2, ACCESS
    sample();
    chk("ifu_a_pen",  64'(bus.mem_penable_o), 64'd1);
    chk("ifu_a_rdy",  64'(bus.ifu_pready_o),  64'd1);
    chk("ifu_a_data", 64'(bus.ifu_prdata_o),  64'h0000_0413);
    chk("ifu_a_lrdy", 64'(bus.lsu_pready_o),  64'd0);
    chk("ifu_a_cnt",  64'(dut.grant_cnt_r),   64'd1);
    next_cycle();
    idle_inputs();
    sample();
    chk("ifu_i_psel",  64'(bus.mem_psel_o),   64'd0);
    chk("ifu_i_rdy",   64'(bus.ifu_pready_o), 64'd0);
    chk("ifu_i_state", 64'(dut.state_r),      64'd0);

    // ---------------- LSU write, 3 memory wait cycles ----------------
    next_cycle();
    bus.lsu_psel_i   = 1'b1;
    bus.lsu_pwrite_i = 1'b1;
    bus.lsu_paddr_i  = 32'hA000_03F8;
    bus.lsu_pwdata_i = 32'h0000_0041;
    bus.lsu_pstrb_i  = 4'h1;
    pen = 0;
    rdy = 0;
    rdy_at = -1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) next_cycle();
      bus.mem_pready_i = (k == 5);
      if (k == 6) idle_inputs();
      sample();
      if (bus.mem_penable_o) pen++;
      if (bus.lsu_pready_o) begin
        rdy++;
        rdy_at = k;
      end
      chk("wr_ifu_rdy", 64'(bus.ifu_pready_o), 64'd0);
      if (k == 1) begin
        chk("wr_s_pwr",   64'(bus.mem_pwrite_o), 64'd1);
        chk("wr_s_paddr", 64'(bus.mem_paddr_o),  64'hA000_03F8);
        chk("wr_s_wdata", 64'(bus.mem_pwdata_o), 64'h41);
        chk("wr_s_pstrb", 64'(bus.mem_pstrb_o),  64'h1);
      end
      if (k == 5) begin
        chk("wr_a_paddr", 64'(bus.mem_paddr_o),   64'hA000_03F8);
        chk("wr_a_wdata", 64'(bus.mem_pwdata_o),  64'h41);
        chk("wr_a_err",   64'(bus.lsu_pslverr_o), 64'd0);
      end
    end
    chk("wr_pen_cycles", 64'(pen),    64'd4);
    chk("wr_rdy_pulses", 64'(rdy),    64'd1);
    chk("wr_rdy_cycle",  64'(rdy_at), 64'd5);

    // ---------------- tie, both requesters held high ----------------
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.ifu_psel_i   = 1'b1;
    bus.ifu_paddr_i  = 32'h0000_1000;
    bus.lsu_psel_i   = 1'b1;
    bus.lsu_pwrite_i = 1'b0;
    bus.lsu_paddr_i  = 32'h0000_2000;
    bus.mem_pready_i = 1'b1;
    bus.mem_prdata_i = 32'h1234_5678;
    n = 0;
    ifu_pulses = 0;
    who = 4'h0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) next_cycle();
      sample();
      chk("tie_excl", 64'(bus.ifu_pready_o & bus.lsu_pready_o), 64'd0);
      if (bus.ifu_pready_o) ifu_pulses++;
      if (bus.ifu_pready_o | bus.lsu_pready_o) begin
        if (n < 4) who[n] = bus.lsu_pready_o;
        chk($sformatf("tie_cnt%0d", n), 64'(dut.grant_cnt_r), 64'(n + 1));
        n++;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    who_exp = 4'b0101;                  // LSU, IFU, LSU, IFU (bit0 first)
    chk("tie_ifu_pulses", 64'(ifu_pulses), 64'd2);
`else
    who_exp = 4'b1111;                  // LSU every time
    chk("tie_ifu_pulses", 64'(ifu_pulses), 64'd0);
`endif
    chk("tie_grants", 64'(n),   64'd4);
    chk("tie_order",  64'(who), 64'(who_exp));
    next_cycle();
    idle_inputs();

    // ---------------- reset in the second ACCESS cycle ----------------
    next_cycle();                       // IDLE
    bus.lsu_psel_i   = 1'b1;
    bus.lsu_paddr_i  = 32'h0000_3000;
    bus.mem_prdata_i = 32'hCAFE_F00D;
    sample();
    next_cycle();                       // SETUP
    sample();
    chk("rsta_s_psel", 64'(bus.mem_psel_o), 64'd1);
    next_cycle();                       // ACCESS, wait
    sample();
    chk("rsta_a1_pen", 64'(bus.mem_penable_o), 64'd1);
    chk("rsta_a1_rdy", 64'(bus.lsu_pready_o),  64'd0);
    next_cycle();                       // ACCESS, reset asserted
    reset = 1'b1;
    bus.mem_pready_i = 1'b1;
    bus.lsu_psel_i   = 1'b0;
    sample();
    chk("rsta_a2_lrdy", 64'(bus.lsu_pready_o), 64'd0);
    chk("rsta_a2_irdy", 64'(bus.ifu_pready_o), 64'd0);
    next_cycle();
    reset = 1'b0;
    sample();
    chk_zero("rsta");

    // ---------------- IFU drops psel mid-ACCESS, slave error ----------------
    next_cycle();
    idle_inputs();
    bus.ifu_psel_i  = 1'b1;
    bus.ifu_paddr_i = 32'h8000_0004;
    sample();                           // IDLE
    next_cycle();                       // SETUP
    sample();
    next_cycle();                       // ACCESS, wait
    bus.ifu_psel_i = 1'b0;
    sample();
    chk("drop_a1_rdy", 64'(bus.ifu_pready_o), 64'd0);
    next_cycle();                       // ACCESS, completes with error
    bus.mem_pready_i  = 1'b1;
    bus.mem_pslverr_i = 1'b1;
    bus.mem_prdata_i  = 32'hDEAD_BEEF;
    sample();
    chk("drop_rdy",   64'(bus.ifu_pready_o),  64'd1);
    chk("drop_data",  64'(bus.ifu_prdata_o),  64'hDEAD_BEEF);
    chk("drop_lerr",  64'(bus.lsu_pslverr_o), 64'd0);
    chk("drop_lrdy",  64'(bus.lsu_pready_o),  64'd0);
    chk("drop_paddr", 64'(bus.mem_paddr_o),   64'h8000_0004);
    next_cycle();
    idle_inputs();
    sample();
    chk("drop_i_rdy",   64'(bus.ifu_pready_o), 64'd0);
    chk("drop_i_state", 64'(dut.state_r),      64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
